// File: rtl/lvds_deframer.sv
// lvds_deframer: assembles recovered nibbles into bytes, checks frame length
// (and optionally CRC-8), and buffers {err,last,byte} entries in a
// first-word-fall-through FIFO feeding a valid/ready byte stream.
// Optional feature macro: LVDS_DEFRAME_CRC_EN (CRC-8, poly 0x07, init 0x00,
// run over every byte of the frame including the trailing CRC byte).
module lvds_deframer #(
    parameter int AW   = 4,
    parameter int MAXB = 64
) (
    input  logic        c,
    input  logic        r,
    input  logic [3:0]  i,
    input  logic        s,
    input  logic        l,
    output logic [7:0]  od,
    output logic        ov,
    input  logic        ordy,
    output logic        olast,
    output logic        oerr,
    output logic [15:0] nframes,
    output logic [15:0] nerrs,
    output logic        ovf
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(MAXB + 1);

    typedef enum logic [1:0] {
        ST_HI      = 2'd0,
        ST_LO      = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // framing state
    state_t          state_reg, state_next;
    logic [3:0]      hi_reg, hi_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CW-1:0]   cnt_inc;
    logic            pend_reg, pend_next;
    logic            frame_rst;
    logic            crc_err;

    // byte produced by the current strobe, before FIFO arbitration
    logic            byte_req;
    logic [7:0]      byte_data;
    logic            byte_last;
    logic            byte_err;

    // FIFO write port
    logic            wr_en;
    logic [9:0]      wr_data;
    logic            ovf_set;

    // FIFO storage and pointers
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   rd_addr;
    logic [AW:0]     fill_reg;
    logic [AW:0]     remaining;
    logic [9:0]      out_reg;
    logic            ov_reg;
    logic            pop;
    logic            full;
    logic            can_wr;
    logic            load;

    // status
    logic [15:0]     nframes_reg;
    logic [15:0]     nerrs_reg;
    logic            ovf_reg;

    assign cnt_inc = cnt_reg + 1'b1;

`ifdef LVDS_DEFRAME_CRC_EN
    logic [7:0] crc_reg;

    // one CRC-8 (poly 0x07) byte step, MSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] x;
        x = crc ^ d;
        for (int k = 0; k < 8; k++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    // remainder after absorbing the byte being completed now; zero means a good frame
    always_comb begin
        crc_err = (crc8_step(crc_reg, {hi_reg, i}) != 8'h00);
    end

    // CRC accumulates each completed byte and restarts at every frame boundary
    always_ff @(posedge c) begin
        if (r) begin
            crc_reg <= 8'h00;
        end else if (frame_rst) begin
            crc_reg <= 8'h00;
        end else if ((state_reg == ST_LO) && s) begin
            crc_reg <= crc8_step(crc_reg, {hi_reg, i});
        end
    end
`else
    assign crc_err = 1'b0;
`endif

    assign pop    = ov_reg && ordy;
    assign full   = (fill_reg == (AW+1)'(DEPTH));
    assign can_wr = !full || pop;

    // framing FSM next state plus FIFO write arbitration (terminator beats a byte)
    always_comb begin
        state_next = state_reg;
        hi_next    = hi_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        byte_req   = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        byte_err   = 1'b0;
        frame_rst  = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 10'h000;
        ovf_set    = 1'b0;

        case (state_reg)
            ST_HI: begin
                if (s) begin
                    hi_next = i;
                    if (l) begin
                        // frame ended on a high nibble: odd length
                        byte_req  = 1'b1;
                        byte_data = {i, 4'h0};
                        byte_last = 1'b1;
                        byte_err  = 1'b1;
                        frame_rst = 1'b1;
                    end else begin
                        state_next = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (s) begin
                    byte_req  = 1'b1;
                    byte_data = {hi_reg, i};
                    cnt_next  = cnt_inc;
                    if (l) begin
                        byte_last  = 1'b1;
                        byte_err   = crc_err;
                        state_next = ST_HI;
                        frame_rst  = 1'b1;
                    end else if (cnt_inc == CW'(MAXB)) begin
                        // too long: tag this byte as a bad end and drop the rest
                        byte_last  = 1'b1;
                        byte_err   = 1'b1;
                        state_next = ST_DISCARD;
                        frame_rst  = 1'b1;
                    end else begin
                        state_next = ST_HI;
                    end
                end
            end
            ST_DISCARD: begin
                if (s && l) begin
                    state_next = ST_HI;
                    frame_rst  = 1'b1;
                end
            end
            default: begin
                state_next = ST_HI;
            end
        endcase

        if (pend_reg) begin
            if (can_wr) begin
                wr_en     = 1'b1;
                wr_data   = {1'b1, 1'b1, 8'h00};
                pend_next = 1'b0;
            end
            // a byte meeting an outstanding terminator loses its whole frame
            if (byte_req) begin
                if (!byte_last) begin
                    state_next = ST_DISCARD;
                end
                frame_rst = 1'b1;
            end
        end else if (byte_req) begin
            if (can_wr) begin
                wr_en   = 1'b1;
                wr_data = {byte_err, byte_last, byte_data};
            end else begin
                ovf_set   = 1'b1;
                pend_next = 1'b1;
                if (!byte_last) begin
                    state_next = ST_DISCARD;
                end
                frame_rst = 1'b1;
            end
        end

        if (frame_rst) begin
            cnt_next = '0;
        end
    end

    // framing state registers
    always_ff @(posedge c) begin
        if (r) begin
            state_reg <= ST_HI;
            hi_reg    <= 4'h0;
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hi_reg    <= hi_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
        end
    end

    // entries not yet copied to the output register
    assign remaining = fill_reg - {{AW{1'b0}}, ov_reg};
    assign load      = (!ov_reg || pop) && (remaining != '0);
    assign rd_addr   = rd_ptr_reg + AW'(pop);

    // FIFO storage write port
    always_ff @(posedge c) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // registered read into the presented entry; held while ov && !ordy
    always_ff @(posedge c) begin
        if (r) begin
            out_reg <= 10'h000;
        end else if (load) begin
            out_reg <= mem[rd_addr];
        end
    end

    // FIFO pointers, occupancy and output valid
    always_ff @(posedge c) begin
        if (r) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            ov_reg     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_addr;
            case ({wr_en, pop})
                2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
                2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
                default: fill_reg <= fill_reg;
            endcase
            if (!ov_reg || pop) begin
                ov_reg <= load;
            end
        end
    end

    // frame/error counters advance when a last-tagged entry is written; overflow is sticky
    always_ff @(posedge c) begin
        if (r) begin
            nframes_reg <= 16'h0000;
            nerrs_reg   <= 16'h0000;
            ovf_reg     <= 1'b0;
        end else begin
            if (wr_en && wr_data[8]) begin
                nframes_reg <= nframes_reg + 16'd1;
                if (wr_data[9]) begin
                    nerrs_reg <= nerrs_reg + 16'd1;
                end
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign od      = out_reg[7:0];
    assign olast   = out_reg[8];
    assign oerr    = out_reg[9];
    assign ov      = ov_reg;
    assign nframes = nframes_reg;
    assign nerrs   = nerrs_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_lvds_deframer.sv
// Directed bench for lvds_deframer (small FIFO, short MAXB so that overflow
// and truncation are reachable). Expected CRC outcomes follow
// LVDS_DEFRAME_CRC_EN when it is defined for the build.
module tb_lvds_deframer;

    localparam int AW   = 2;
    localparam int MAXB = 6;
`ifdef LVDS_DEFRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        c = 1'b0;
    logic        r = 1'b1;
    logic [3:0]  i = 4'h0;
    logic        s = 1'b0;
    logic        l = 1'b0;
    logic        ordy = 1'b1;
    logic [7:0]  od;
    logic        ov;
    logic        olast;
    logic        oerr;
    logic [15:0] nframes;
    logic [15:0] nerrs;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    lvds_deframer #(.AW(AW), .MAXB(MAXB)) dut (
        .c       (c),
        .r       (r),
        .i       (i),
        .s       (s),
        .l       (l),
        .od      (od),
        .ov      (ov),
        .ordy    (ordy),
        .olast   (olast),
        .oerr    (oerr),
        .nframes (nframes),
        .nerrs   (nerrs),
        .ovf     (ovf)
    );

    always #5 c = ~c;

    // record every stream transfer, one line each
    always @(negedge c) begin
        if (ov && ordy) begin
            got_q.push_back({oerr, olast, od});
            $display("xfer od=%02h last=%0b err=%0b", od, olast, oerr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one strobed nibble followed by at least one idle cycle
    task automatic nib(input logic [3:0] n, input logic last);
        @(posedge c); #1;
        i = n; s = 1'b1; l = last;
        @(posedge c); #1;
        s = 1'b0; l = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge c);
        #1;
    endtask

    task automatic compare_q(input string tag);
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("%s_entry%0d", tag, k), got_q[k], exp_q[k]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge c);
        #1;
        check("rst_ov", ov, 0);
        check("rst_od", od, 0);
        check("rst_olast", olast, 0);
        check("rst_oerr", oerr, 0);
        check("rst_nframes", nframes, 0);
        check("rst_nerrs", nerrs, 0);
        check("rst_ovf", ovf, 0);
        r = 1'b0;
        idle(2);

        // good frame 01 07, with first-byte latency
        nib(4'h0, 1'b0);
        nib(4'h1, 1'b0);
        check("lat_edge1_ov", ov, 0);
        @(posedge c); #1;
        check("lat_edge2_ov", ov, 1);
        check("lat_edge2_od", od, 8'h01);
        nib(4'h0, 1'b0);
        nib(4'h7, 1'b1);
        idle(6);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h107);
        compare_q("good");
        check("good_nframes", nframes, 1);
        check("good_nerrs", nerrs, 0);

        // frame 01 06: CRC remainder non-zero when CRC is built in
        nib(4'h0, 1'b0); nib(4'h1, 1'b0);
        nib(4'h0, 1'b0); nib(4'h6, 1'b1);
        idle(6);
        exp_q.push_back(10'h001);
        exp_q.push_back({CRC_ON, 1'b1, 8'h06});
        compare_q("crcbad");
        check("crcbad_nframes", nframes, 2);
        check("crcbad_nerrs", nerrs, CRC_ON ? 1 : 0);

        // odd-length frame A,5,3 then a normal frame
        nib(4'hA, 1'b0); nib(4'h5, 1'b0); nib(4'h3, 1'b1);
        nib(4'h0, 1'b0); nib(4'h1, 1'b0);
        nib(4'h0, 1'b0); nib(4'h7, 1'b1);
        idle(6);
        exp_q.push_back(10'h0A5);
        exp_q.push_back(10'h330);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h107);
        compare_q("odd");
        check("odd_nframes", nframes, 4);
        check("odd_nerrs", nerrs, CRC_ON ? 2 : 1);

        // 16 nibbles of F: truncated at MAXB=6 bytes, last 4 nibbles dropped
        for (int k = 0; k < 16; k++) begin
            nib(4'hF, (k == 15));
        end
        idle(8);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(10'h0FF);
        end
        exp_q.push_back(10'h3FF);
        compare_q("maxb");
        check("maxb_nframes", nframes, 5);
        check("maxb_nerrs", nerrs, CRC_ON ? 3 : 2);

        // overflow: 6-byte frame into a 4-entry FIFO with the sink stalled
        ordy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            nib(4'(k), 1'b0);
            nib(4'(k), (k == 6));
        end
        idle(4);
        check("ovf_flag", ovf, 1);
        check("ovf_held_ov", ov, 1);
        check("ovf_held_od", od, 8'h11);
        check("ovf_pre_nframes", nframes, 5);
        ordy = 1'b1;
        idle(20);
        exp_q.push_back(10'h011);
        exp_q.push_back(10'h022);
        exp_q.push_back(10'h033);
        exp_q.push_back(10'h044);
        exp_q.push_back(10'h300);
        compare_q("ovf");
        check("ovf_nframes", nframes, 6);
        check("ovf_nerrs", nerrs, CRC_ON ? 4 : 3);

        // reset after a lone high nibble: partial frame lost
        nib(4'hC, 1'b0);
        @(posedge c); #1;
        r = 1'b1;
        @(posedge c); #1;
        r = 1'b0;
        check("mid_rst_ov", ov, 0);
        check("mid_rst_nframes", nframes, 0);
        check("mid_rst_nerrs", nerrs, 0);
        check("mid_rst_ovf", ovf, 0);
        nib(4'h1, 1'b0);
        nib(4'h2, 1'b1);
        idle(6);
        exp_q.push_back({CRC_ON, 1'b1, 8'h12});
        compare_q("post_rst");
        check("post_rst_nframes", nframes, 1);
        check("post_rst_nerrs", nerrs, CRC_ON ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
